// File: rtl/alu_mp_if.sv
// alu_mp_if: request/result bus and ALU-side byte bus of the multi-precision sequencer (optional carry_in under ALU_MP_CARRY_IN_EN)
interface alu_mp_if #(parameter int WORDS = 4);
  localparam int W = 8 * WORDS;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
`ifdef ALU_MP_CARRY_IN_EN
  logic         carry_in;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         sign;
  logic         overflow;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_op;
  logic [7:0]   alu_out;
  logic         alu_cout;
`ifdef ALU_MP_CARRY_IN_EN
  modport master (output start, op, a_in, b_in, carry_in, alu_out, alu_cout,
                  input busy, done, result, carry_out, zero, sign, overflow, alu_a, alu_b, alu_cin, alu_op);
  modport slave (input start, op, a_in, b_in, carry_in, alu_out, alu_cout,
                 output busy, done, result, carry_out, zero, sign, overflow, alu_a, alu_b, alu_cin, alu_op);
`else
  modport master (output start, op, a_in, b_in, alu_out, alu_cout,
                  input busy, done, result, carry_out, zero, sign, overflow, alu_a, alu_b, alu_cin, alu_op);
  modport slave (input start, op, a_in, b_in, alu_out, alu_cout,
                 output busy, done, result, carry_out, zero, sign, overflow, alu_a, alu_b, alu_cin, alu_op);
`endif
endinterface

// File: rtl/alu_mp_sequencer.sv
// alu_mp_sequencer: drives an 8-bit ALU one byte per clock, LSB first, to build a WORDS-byte result and flags (optional byte-0 carry_in under ALU_MP_CARRY_IN_EN)
module alu_mp_sequencer #(
  parameter int WORDS = 4
) (
  input logic     clk,
  input logic     rst,
  alu_mp_if.slave bus
);
  localparam int W = 8 * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, b_q, res_q;
  logic [2:0] op_q;
  logic [IW-1:0] idx_q;
  logic c_q, nz_q, co_q, z_q, s_q, v_q;
  logic run, last, arith, accept, cin0;
  assign run = state_q == RUN;
  assign last = idx_q == IW'(WORDS - 1);
  assign arith = op_q == OP_ADD || op_q == OP_SUB;
  assign accept = state_q == IDLE && bus.start;
`ifdef ALU_MP_CARRY_IN_EN
  logic cin0_q;
  // byte-0 carry/borrow-in is captured together with the operands
  always_ff @(posedge clk)
    if (rst) cin0_q <= 1'b0;
    else if (accept) cin0_q <= bus.carry_in;
  assign cin0 = cin0_q;
`else
  assign cin0 = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  // IDLE -> RUN on start, RUN -> DONE after the last byte, DONE lasts one cycle
  always_comb begin
    state_d = state_q == IDLE ? (bus.start ? RUN : IDLE) :
              state_q == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // operand latch, per-byte capture and final flag evaluation
  always_ff @(posedge clk)
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      idx_q <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      nz_q  <= 1'b0;
      co_q  <= 1'b0;
      z_q   <= 1'b0;
      s_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a_in;
      b_q   <= bus.b_in;
      op_q  <= bus.op;
      idx_q <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
      nz_q  <= 1'b0;
    end else if (run) begin
      res_q[8*idx_q +: 8] <= bus.alu_out;
      c_q   <= bus.alu_cout;
      nz_q  <= nz_q | (|bus.alu_out);
      idx_q <= idx_q + IW'(1);
      if (last) begin
        co_q <= arith & bus.alu_cout;
        z_q  <= ~(nz_q | (|bus.alu_out));
        s_q  <= bus.alu_out[7];
        v_q  <= op_q == OP_ADD ? (a_q[W-1] == b_q[W-1]) && (bus.alu_out[7] != a_q[W-1]) :
                op_q == OP_SUB ? (a_q[W-1] != b_q[W-1]) && (bus.alu_out[7] != a_q[W-1]) : 1'b0;
      end
    end
  // ALU drive while running; sub chains the inverted carry since the ALU flips Cin for Op[2]
  always_comb begin
    bus.busy      = run;
    bus.done      = state_q == DONE;
    bus.result    = res_q;
    bus.carry_out = co_q;
    bus.zero      = z_q;
    bus.sign      = s_q;
    bus.overflow  = v_q;
    bus.alu_a     = run ? a_q[8*idx_q +: 8] : 8'h00;
    bus.alu_b     = run ? b_q[8*idx_q +: 8] : 8'h00;
    bus.alu_op    = run ? op_q : 3'b000;
    bus.alu_cin   = !run          ? 1'b0 :
                    idx_q == '0   ? arith & cin0 :
                    op_q == OP_ADD ? c_q :
                    op_q == OP_SUB ? ~c_q : 1'b0;
  end
endmodule
